// File: rtl/qam_demodulator_pkg.sv
// qam_demodulator_pkg: shared FSM state type and per-axis 16-QAM level codes.
package qam_demodulator_pkg;
  typedef enum logic {SEEK, ACCUM} QAMDemodState;
  localparam logic [1:0] QAM_LVL_P1 = 2'b00;
  localparam logic [1:0] QAM_LVL_P3 = 2'b01;
  localparam logic [1:0] QAM_LVL_N1 = 2'b10;
  localparam logic [1:0] QAM_LVL_N3 = 2'b11;
endpackage

// File: rtl/qam_demodulator_axis_slicer.sv
// qam_axis_slicer: decides one axis level from its correlation and carrier energy.
module qam_axis_slicer
  import qam_demodulator_pkg::*;
#(
  parameter int W = 44
) (
  input  logic signed [W-1:0] corr_i,
  input  logic        [W-1:0] en_i,
  output logic        [1:0]   code_o
);
  logic       neg;
  logic [W:0] mag_abs;
  logic [W:0] thr;
  // One extra bit keeps |corr| and 2*en exact at the extremes of the accumulator range.
  always_comb begin
    neg     = corr_i[W-1];
    mag_abs = neg ? ~{1'b1, corr_i} + (W+1)'(1) : {1'b0, corr_i};
    thr     = {en_i, 1'b0};
    code_o  = neg ? (mag_abs > thr ? QAM_LVL_N3 : QAM_LVL_N1)
                  : (mag_abs > thr ? QAM_LVL_P3 : QAM_LVL_P1);
  end
endmodule

// File: rtl/qam_demodulator.sv
// qam_demodulator: coherent 16-QAM integrate-and-dump demodulator with symbol-start tracking.
module qam_demodulator
  import qam_demodulator_pkg::*;
#(
  parameter int SYMBOL_LEN = 16,
  parameter int ACC_W      = 38 + $clog2(SYMBOL_LEN) + 2
) (
  input  logic               ipClk,
  input  logic               ipReset,
  input  logic signed [19:0] ipModulated,
  input  logic signed [17:0] ipI,
  input  logic signed [17:0] ipQ,
  input  logic               ipValid,
  input  logic               ipSymbolStart,
  output logic [3:0]         opQAMBlock,
  output logic               opQAMBlockValid,
  output logic               opLocked,
  output logic               opSyncError
);
  localparam int CNT_W = $clog2(SYMBOL_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_LEN - 1);
  QAMDemodState state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sync_err_q, sync_err_d;
  logic signed [37:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic [35:0] e_i_q, e_i_d, e_q_q, e_q_d;
  logic s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [ACC_W-1:0] acc_ci_q, acc_ci_d, acc_cq_q, acc_cq_d;
  logic [ACC_W-1:0] acc_ei_q, acc_ei_d, acc_eq_q, acc_eq_d;
  logic signed [ACC_W-1:0] dump_ci_q, dump_ci_d, dump_cq_q, dump_cq_d;
  logic [ACC_W-1:0] dump_ei_q, dump_ei_d, dump_eq_q, dump_eq_d;
  logic dump_vld_q, dump_vld_d;
  logic signed [ACC_W-1:0] sum_ci, sum_cq;
  logic [ACC_W-1:0] sum_ei, sum_eq;
  logic [3:0] blk_q, blk_d;
  logic blk_vld_q, blk_vld_d;
  logic [1:0] code_i, code_q;
  // Sample framing is decided at the input so first/last flags ride with the products;
  // a resync sample is flagged first, which makes stage 2 drop the partial sums.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    s1_vld_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;
    p_i_d      = ipValid ? 38'(ipModulated) * 38'(ipI) : p_i_q;
    p_q_d      = ipValid ? 38'(ipModulated) * 38'(ipQ) : p_q_q;
    e_i_d      = ipValid ? $unsigned(36'(ipI) * 36'(ipI)) : e_i_q;
    e_q_d      = ipValid ? $unsigned(36'(ipQ) * 36'(ipQ)) : e_q_q;
    if (ipValid && state_q == SEEK && ipSymbolStart) begin
      state_d    = ACCUM;
      cnt_d      = CNT_W'(1);
      s1_vld_d   = 1'b1;
      s1_first_d = 1'b1;
    end else if (ipValid && state_q == ACCUM) begin
      s1_vld_d   = 1'b1;
      s1_first_d = ipSymbolStart || cnt_q == '0;
      s1_last_d  = !ipSymbolStart && cnt_q == LAST;
      sync_err_d = ipSymbolStart && cnt_q != '0;
      cnt_d      = ipSymbolStart ? CNT_W'(1) : (cnt_q == LAST ? '0 : cnt_q + CNT_W'(1));
    end
  end
  always_comb begin
    sum_ci     = (s1_first_q ? '0 : acc_ci_q) + {{(ACC_W-38){p_i_q[37]}}, p_i_q};
    sum_cq     = (s1_first_q ? '0 : acc_cq_q) + {{(ACC_W-38){p_q_q[37]}}, p_q_q};
    sum_ei     = (s1_first_q ? '0 : acc_ei_q) + ACC_W'(e_i_q);
    sum_eq     = (s1_first_q ? '0 : acc_eq_q) + ACC_W'(e_q_q);
    acc_ci_d   = acc_ci_q;
    acc_cq_d   = acc_cq_q;
    acc_ei_d   = acc_ei_q;
    acc_eq_d   = acc_eq_q;
    dump_ci_d  = dump_ci_q;
    dump_cq_d  = dump_cq_q;
    dump_ei_d  = dump_ei_q;
    dump_eq_d  = dump_eq_q;
    dump_vld_d = s1_vld_q && s1_last_q;
    if (s1_vld_q && s1_last_q) begin
      dump_ci_d = sum_ci;
      dump_cq_d = sum_cq;
      dump_ei_d = sum_ei;
      dump_eq_d = sum_eq;
      acc_ci_d  = '0;
      acc_cq_d  = '0;
      acc_ei_d  = '0;
      acc_eq_d  = '0;
    end else if (s1_vld_q) begin
      acc_ci_d = sum_ci;
      acc_cq_d = sum_cq;
      acc_ei_d = sum_ei;
      acc_eq_d = sum_eq;
    end
    blk_d     = dump_vld_q ? {code_q, code_i} : blk_q;
    blk_vld_d = dump_vld_q;
  end
  qam_axis_slicer #(.W(ACC_W)) u_slice_i (.corr_i(dump_ci_q), .en_i(dump_ei_q), .code_o(code_i));
  qam_axis_slicer #(.W(ACC_W)) u_slice_q (.corr_i(dump_cq_q), .en_i(dump_eq_q), .code_o(code_q));
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q    <= SEEK;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
      p_i_q      <= '0;
      p_q_q      <= '0;
      e_i_q      <= '0;
      e_q_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_ci_q   <= '0;
      acc_cq_q   <= '0;
      acc_ei_q   <= '0;
      acc_eq_q   <= '0;
      dump_ci_q  <= '0;
      dump_cq_q  <= '0;
      dump_ei_q  <= '0;
      dump_eq_q  <= '0;
      dump_vld_q <= 1'b0;
      blk_q      <= '0;
      blk_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
      p_i_q      <= p_i_d;
      p_q_q      <= p_q_d;
      e_i_q      <= e_i_d;
      e_q_q      <= e_q_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      acc_ci_q   <= acc_ci_d;
      acc_cq_q   <= acc_cq_d;
      acc_ei_q   <= acc_ei_d;
      acc_eq_q   <= acc_eq_d;
      dump_ci_q  <= dump_ci_d;
      dump_cq_q  <= dump_cq_d;
      dump_ei_q  <= dump_ei_d;
      dump_eq_q  <= dump_eq_d;
      dump_vld_q <= dump_vld_d;
      blk_q      <= blk_d;
      blk_vld_q  <= blk_vld_d;
    end
  end
  assign opQAMBlock      = blk_q;
  assign opQAMBlockValid = blk_vld_q;
  assign opLocked        = state_q == ACCUM;
  assign opSyncError     = sync_err_q;
endmodule

// File: tb/tb_qam_demodulator.sv
// tb_qam_demodulator: table-driven and randomized checks against a symbol-level reference model.
module tb_qam_demodulator;
  localparam int L = 16;
  logic clk = 1'b0;
  logic rst;
  logic signed [19:0] mod;
  logic signed [17:0] ri, rq;
  logic vld, st;
  logic [3:0] blk;
  logic blk_vld, locked, sync_err;
  qam_demodulator #(.SYMBOL_LEN(L)) dut (
    .ipClk(clk), .ipReset(rst), .ipModulated(mod), .ipI(ri), .ipQ(rq),
    .ipValid(vld), .ipSymbolStart(st), .opQAMBlock(blk), .opQAMBlockValid(blk_vld),
    .opLocked(locked), .opSyncError(sync_err)
  );
  always #5 clk = ~clk;
  typedef struct { longint due; logic [3:0] code; } exp_t;
  typedef struct { int ai; int aq; logic [3:0] code; } vec_t;
  exp_t blk_exp[$];
  longint sync_exp[$];
  logic [3:0] got[$];
  vec_t tbl[18];
  int tests = 0, fails = 0, sync_cnt = 0;
  longint cyc = 0;
  bit m_lock = 0;
  int m_idx = 0;
  longint m_ci, m_cq, m_ei, m_eq;
  bit ev, es;
  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [1:0] axis(longint c, longint e);
    return {c < 0, (c < 0 ? -c : c) > 2 * e};
  endfunction
  function automatic int lvl(logic [1:0] b);
    return b == 2'd0 ? 1 : b == 2'd1 ? 3 : b == 2'd2 ? -1 : -3;
  endfunction
  function automatic int iref(int n);
    return n % 4 == 0 ? 1000 : n % 4 == 2 ? -1000 : 0;
  endfunction
  function automatic int qref(int n);
    return n % 4 == 1 ? 1000 : n % 4 == 3 ? -1000 : 0;
  endfunction
  // Symbol-level model: sums products over L accepted samples, restarts on any mid-symbol start.
  task automatic model(int m, int i, int q, bit s);
    longint pi = longint'(m) * i, pq = longint'(m) * q;
    longint ei = longint'(i) * i, eq = longint'(q) * q;
    if (!m_lock && !s) return;
    if (m_lock && s && m_idx != 0) sync_exp.push_back(cyc);
    if (s || m_idx == 0) begin
      m_ci = pi; m_cq = pq; m_ei = ei; m_eq = eq; m_idx = 1;
    end else begin
      m_ci += pi; m_cq += pq; m_ei += ei; m_eq += eq; m_idx++;
    end
    m_lock = 1;
    if (m_idx == L) begin
      blk_exp.push_back('{cyc + 2, {axis(m_cq, m_eq), axis(m_ci, m_ei)}});
      m_idx = 0;
    end
  endtask
  task automatic step(bit v, bit s, int m, int i, int q);
    @(negedge clk);
    vld = v; st = s; mod = 20'(m); ri = 18'(i); rq = 18'(q);
    @(posedge clk);
    cyc++;
    if (v && !rst) model(m, i, q, s);
  endtask
  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask
  task automatic send_sym(int ai, int aq, bit start, bit bubbles, int noise, int nsamp);
    for (int n = 0; n < nsamp; n++) begin
      int nz = noise > 0 ? int'($urandom_range(0, 2 * noise)) - noise : 0;
      if (bubbles) step(0, 0, 0, 0, 0);
      step(1, start && n == 0, ai * iref(n) + aq * qref(n) + nz, iref(n), qref(n));
    end
  endtask
  task automatic check_got(string name, int first, int n);
    chk({name, "_count"}, got.size(), n);
    for (int k = 0; k < n && k < got.size(); k++) chk(name, got[k], tbl[first + k].code);
  endtask
  always @(negedge clk) begin
    ev = blk_exp.size() > 0 && blk_exp[0].due == cyc;
    es = sync_exp.size() > 0 && sync_exp[0] == cyc;
    chk("blk_valid", blk_vld, ev);
    if (blk_vld) got.push_back(blk);
    if (ev) begin
      chk("blk_code", blk, blk_exp[0].code);
      void'(blk_exp.pop_front());
    end
    chk("sync_err", sync_err, es);
    if (sync_err) sync_cnt++;
    if (es) void'(sync_exp.pop_front());
    chk("locked", locked, m_lock);
  end
  initial begin
    logic [3:0] kb;
    for (int k = 0; k < 16; k++) begin
      kb = 4'(k);
      tbl[k] = '{lvl(kb[1:0]), lvl(kb[3:2]), kb};
    end
    tbl[16] = '{2, 0, 4'h0};
    tbl[17] = '{-3, -3, 4'hF};
    rst = 1; vld = 0; st = 0; mod = 0; ri = 0; rq = 0;
    idle(2);
    chk("rst_blk", blk, 0);
    chk("rst_blk_valid", blk_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sync", sync_err, 0);
    @(negedge clk) rst = 0;
    idle(2);
    got.delete(); sync_cnt = 0;
    for (int k = 0; k < 18; k++) send_sym(tbl[k].ai, tbl[k].aq, k == 0, 0, 0, L);
    idle(4);
    check_got("contig", 0, 18);
    chk("contig_sync", sync_cnt, 0);
    got.delete();
    for (int k = 0; k < 18; k++) send_sym(tbl[k].ai, tbl[k].aq, k == 0, 1, 0, L);
    idle(6);
    check_got("bubble", 0, 18);
    chk("bubble_sync", sync_cnt, 0);
    got.delete();
    for (int k = 0; k < 3; k++) send_sym(tbl[k].ai, tbl[k].aq, k == 0, 0, 0, L);
    send_sym(tbl[3].ai, tbl[3].aq, 0, 0, 0, 7);
    send_sym(tbl[4].ai, tbl[4].aq, 1, 0, 0, L);
    send_sym(tbl[5].ai, tbl[5].aq, 0, 0, 0, L);
    idle(4);
    chk("resync_sync", sync_cnt, 1);
    chk("resync_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("resync_c0", got[0], 0); chk("resync_c1", got[1], 1); chk("resync_c2", got[2], 2);
      chk("resync_c3", got[3], 4); chk("resync_c4", got[4], 5);
    end
    send_sym(tbl[5].ai, tbl[5].aq, 1, 0, 0, L);
    idle(4);
    send_sym(tbl[6].ai, tbl[6].aq, 0, 0, 0, 9);
    #2 rst = 1;
    #1;
    chk("arst_blk", blk, 0);
    chk("arst_blk_valid", blk_vld, 0);
    chk("arst_locked", locked, 0);
    chk("arst_sync", sync_err, 0);
    m_lock = 0; m_idx = 0; blk_exp.delete(); sync_exp.delete();
    @(negedge clk) rst = 0;
    got.delete();
    send_sym(tbl[7].ai, tbl[7].aq, 0, 0, 0, L);
    idle(4);
    chk("arst_nostart", got.size(), 0);
    send_sym(tbl[8].ai, tbl[8].aq, 1, 0, 0, L);
    idle(4);
    check_got("arst_restart", 8, 1);
    got.delete();
    for (int k = 0; k < 16; k++) send_sym(tbl[k].ai, tbl[k].aq, k == 0, 0, 150, L);
    idle(4);
    check_got("noise", 0, 16);
    for (int r = 0; r < 40; r++)
      send_sym(int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
               $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3000)),
               $urandom_range(0, 4) == 0 ? int'($urandom_range(1, L)) : L);
    for (int r = 0; r < 600; r++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           int'($urandom_range(0, 1048575)) - 524288,
           int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072);
    idle(6);
    chk("pending_blk", blk_exp.size(), 0);
    chk("pending_sync", sync_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
